// File: rtl/pc_label_unit.sv
// rtl/pc_label_unit.sv - registered PC with programmable label table and return stack
module pc_label_unit #(
    parameter int PC_W        = 8,
    parameter int NUM_LABELS  = 8,
    parameter int IDX_W       = $clog2(NUM_LABELS),
    parameter int STACK_DEPTH = 4,
    parameter int PC_STEP     = 4,
    parameter int RESET_PC    = 0,
    localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic [IDX_W-1:0] label_idx,
    input  logic [PC_W-1:0]  abs_target,
    input  logic             cond,
    input  logic             lbl_we,
    input  logic [IDX_W-1:0] lbl_waddr,
    input  logic [PC_W-1:0]  lbl_wdata,
    output logic [PC_W-1:0]  pc,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] stack_cnt
);

    localparam logic [2:0] OP_SEQ     = 3'b000;
    localparam logic [2:0] OP_JMP_LBL = 3'b001;
    localparam logic [2:0] OP_BR_LBL  = 3'b010;
    localparam logic [2:0] OP_JMP_ABS = 3'b011;
    localparam logic [2:0] OP_CALL    = 3'b100;
    localparam logic [2:0] OP_RET     = 3'b101;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_LABEL = 2'b01;
    localparam logic [1:0] ERR_STACK = 2'b10;
    localparam logic [1:0] ERR_OP    = 2'b11;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PC_W-1:0]       pc_q, pc_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_LABELS-1:0] vld_q, vld_d;
    logic [PC_W-1:0]       tab_q [NUM_LABELS];
    logic [PC_W-1:0]       tab_d [NUM_LABELS];
    logic [PC_W-1:0]       stk_q [STACK_DEPTH];
    logic [PC_W-1:0]       stk_d [STACK_DEPTH];

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] top;
    logic            lbl_hit;
    logic [PC_W-1:0] lbl_val;
    logic            push;

    // Label writes land regardless of stall; lookups see only the registered table.
    always_comb begin
        vld_d = vld_q;
        tab_d = tab_q;
        if (lbl_we) begin
            vld_d[lbl_waddr] = 1'b1;
            tab_d[lbl_waddr] = lbl_wdata;
        end
    end

    // Next-PC resolution, stack push/pop and error classification.
    always_comb begin
        seq     = pc_q + PC_W'(PC_STEP);
        lbl_hit = vld_q[label_idx];
        lbl_val = tab_q[label_idx];
        top     = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (int'(cnt_q) == i + 1) top = stk_q[i];
        end
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        code_d = ERR_NONE;
        push   = 1'b0;
        if (!stall) begin
            pc_d = seq;
            case (op)
                OP_SEQ: ;
                OP_JMP_LBL, OP_BR_LBL: begin
                    if (op == OP_JMP_LBL || cond) begin
                        if (lbl_hit) begin
                            pc_d = lbl_val;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_LABEL;
                        end
                    end
                end
                OP_JMP_ABS: pc_d = abs_target;
                OP_CALL: begin
                    // An unknown label is reported ahead of a full stack.
                    if (!lbl_hit) begin
                        err_d  = 1'b1;
                        code_d = ERR_LABEL;
                    end else if (cnt_q == CNT_FULL) begin
                        err_d  = 1'b1;
                        code_d = ERR_STACK;
                    end else begin
                        push  = 1'b1;
                        pc_d  = lbl_val;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                OP_RET: begin
                    if (cnt_q != '0) begin
                        pc_d  = top;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_STACK;
                    end
                end
                default: begin
                    err_d  = 1'b1;
                    code_d = ERR_OP;
                end
            endcase
        end
        stk_d = stk_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && int'(cnt_q) == i) stk_d[i] = seq;
        end
    end

    // State registers; reset clears PC, errors, stack depth and label validity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= PC_W'(RESET_PC);
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            cnt_q  <= '0;
            vld_q  <= '0;
            for (int i = 0; i < NUM_LABELS; i++) tab_q[i] <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            err_q  <= err_d;
            code_q <= code_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            tab_q  <= tab_d;
            stk_q  <= stk_d;
        end
    end

    assign pc        = pc_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign stack_cnt = cnt_q;

endmodule

// File: tb/tb_pc_label_unit.sv
// tb/tb_pc_label_unit.sv - table-driven bench for pc_label_unit
module tb_pc_label_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic [2:0] op;
    logic [2:0] label_idx;
    logic [7:0] abs_target;
    logic       cond;
    logic       lbl_we;
    logic [2:0] lbl_waddr;
    logic [7:0] lbl_wdata;
    logic [7:0] pc;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] stack_cnt;

    int checks   = 0;
    int failures = 0;

    pc_label_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .label_idx(label_idx),
        .abs_target(abs_target), .cond(cond), .lbl_we(lbl_we), .lbl_waddr(lbl_waddr),
        .lbl_wdata(lbl_wdata), .pc(pc), .err(err), .err_code(err_code), .stack_cnt(stack_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [2:0] op;
        logic [2:0] idx;
        logic [7:0] abs;
        logic       cnd;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [7:0] e_pc;
        logic       e_err;
        logic [1:0] e_code;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BR = 3'd2, ABS = 3'd3, CALL = 3'd4, RET = 3'd5;

    task automatic add(input logic st, input logic [2:0] o, input logic [2:0] i, input logic [7:0] a,
                       input logic c, input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [7:0] ep, input logic ee, input logic [1:0] ec, input logic [2:0] en);
        vec_t v;
        v.st = st; v.op = o; v.idx = i; v.abs = a; v.cnd = c; v.we = w; v.wa = wa; v.wd = wd;
        v.e_pc = ep; v.e_err = ee; v.e_code = ec; v.e_cnt = en;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] ep, input logic ee,
                         input logic [1:0] ec, input logic [2:0] en);
        checks++;
        if (pc !== ep) begin failures++; $display("FAIL %s pc got=%h exp=%h", name, pc, ep); end
        checks++;
        if (err !== ee) begin failures++; $display("FAIL %s err got=%b exp=%b", name, err, ee); end
        checks++;
        if (err_code !== ec) begin failures++; $display("FAIL %s err_code got=%b exp=%b", name, err_code, ec); end
        checks++;
        if (stack_cnt !== en) begin failures++; $display("FAIL %s stack_cnt got=%0d exp=%0d", name, stack_cnt, en); end
    endtask

    task automatic drive(input logic st, input logic [2:0] o, input logic [2:0] i, input logic [7:0] a,
                         input logic c, input logic w, input logic [2:0] wa, input logic [7:0] wd);
        stall = st; op = o; label_idx = i; abs_target = a; cond = c;
        lbl_we = w; lbl_waddr = wa; lbl_wdata = wd;
    endtask

    initial begin
        //   st op   idx abs   c  we wa wd     pc    err code cnt
        add(0, SEQ, 0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 0, 2'b00, 0);
        add(0, SEQ, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08, 0, 2'b00, 0);
        add(0, SEQ, 0, 8'h00, 0, 0, 0, 8'h00, 8'h0C, 0, 2'b00, 0);
        add(0, SEQ, 0, 8'h00, 0, 1, 2, 8'h38, 8'h10, 0, 2'b00, 0);
        add(0, JMP, 2, 8'h00, 0, 0, 0, 8'h00, 8'h38, 0, 2'b00, 0);
        add(0, JMP, 5, 8'h00, 0, 0, 0, 8'h00, 8'h3C, 1, 2'b01, 0);
        add(0, SEQ, 0, 8'h00, 0, 1, 3, 8'h50, 8'h40, 0, 2'b00, 0);
        add(0, ABS, 0, 8'h10, 0, 1, 1, 8'h20, 8'h10, 0, 2'b00, 0);
        add(0, CALL,3, 8'h00, 0, 0, 0, 8'h00, 8'h50, 0, 2'b00, 1);
        add(0, SEQ, 0, 8'h00, 0, 0, 0, 8'h00, 8'h54, 0, 2'b00, 1);
        add(0, RET, 0, 8'h00, 0, 0, 0, 8'h00, 8'h14, 0, 2'b00, 0);
        add(0, RET, 0, 8'h00, 0, 0, 0, 8'h00, 8'h18, 1, 2'b10, 0);
        add(0, SEQ, 0, 8'h00, 0, 0, 0, 8'h00, 8'h1C, 0, 2'b00, 0);
        add(0, CALL,3, 8'h00, 0, 0, 0, 8'h00, 8'h50, 0, 2'b00, 1);
        add(0, ABS, 0, 8'h70, 0, 0, 0, 8'h00, 8'h70, 0, 2'b00, 1);
        add(0, CALL,3, 8'h00, 0, 0, 0, 8'h00, 8'h50, 0, 2'b00, 2);
        add(0, ABS, 0, 8'h90, 0, 0, 0, 8'h00, 8'h90, 0, 2'b00, 2);
        add(0, CALL,3, 8'h00, 0, 0, 0, 8'h00, 8'h50, 0, 2'b00, 3);
        add(0, ABS, 0, 8'hB0, 0, 0, 0, 8'h00, 8'hB0, 0, 2'b00, 3);
        add(0, CALL,3, 8'h00, 0, 0, 0, 8'h00, 8'h50, 0, 2'b00, 4);
        add(0, CALL,3, 8'h00, 0, 0, 0, 8'h00, 8'h54, 1, 2'b10, 4);
        add(0, CALL,6, 8'h00, 0, 0, 0, 8'h00, 8'h58, 1, 2'b01, 4);
        add(0, RET, 0, 8'h00, 0, 0, 0, 8'h00, 8'hB4, 0, 2'b00, 3);
        add(0, RET, 0, 8'h00, 0, 0, 0, 8'h00, 8'h94, 0, 2'b00, 2);
        add(0, RET, 0, 8'h00, 0, 0, 0, 8'h00, 8'h74, 0, 2'b00, 1);
        add(0, RET, 0, 8'h00, 0, 0, 0, 8'h00, 8'h20, 0, 2'b00, 0);
        add(0, JMP, 1, 8'h00, 0, 1, 1, 8'h80, 8'h20, 0, 2'b00, 0);
        add(0, JMP, 1, 8'h00, 0, 0, 0, 8'h00, 8'h80, 0, 2'b00, 0);
        add(0, BR,  5, 8'h00, 0, 0, 0, 8'h00, 8'h84, 0, 2'b00, 0);
        add(0, BR,  5, 8'h00, 1, 0, 0, 8'h00, 8'h88, 1, 2'b01, 0);
        add(0, BR,  2, 8'h00, 1, 0, 0, 8'h00, 8'h38, 0, 2'b00, 0);
        add(0, BR,  2, 8'h00, 0, 0, 0, 8'h00, 8'h3C, 0, 2'b00, 0);
        add(0, 3'd6,0, 8'h00, 0, 0, 0, 8'h00, 8'h40, 1, 2'b11, 0);
        add(1, ABS, 0, 8'h44, 0, 0, 0, 8'h00, 8'h40, 0, 2'b00, 0);
        add(1, 3'd7,0, 8'h00, 0, 1, 7, 8'hA8, 8'h40, 0, 2'b00, 0);
        add(0, 3'd7,0, 8'h00, 0, 0, 0, 8'h00, 8'h44, 1, 2'b11, 0);
        add(0, JMP, 7, 8'h00, 0, 0, 0, 8'h00, 8'hA8, 0, 2'b00, 0);
        add(0, ABS, 0, 8'hFC, 0, 0, 0, 8'h00, 8'hFC, 0, 2'b00, 0);
        add(0, SEQ, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 2'b00, 0);
        add(1, ABS, 0, 8'h44, 0, 0, 0, 8'h00, 8'h00, 0, 2'b00, 0);
        add(0, SEQ, 0, 8'h00, 0, 0, 0, 8'h00, 8'h04, 0, 2'b00, 0);

        rst_n = 1'b0;
        drive(0, SEQ, 0, 8'h00, 0, 0, 0, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        check("reset", 8'h00, 1'b0, 2'b00, 3'd0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].st, vecs[k].op, vecs[k].idx, vecs[k].abs, vecs[k].cnd,
                  vecs[k].we, vecs[k].wa, vecs[k].wd);
            @(posedge clk); #1;
            check($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_err, vecs[k].e_code, vecs[k].e_cnt);
        end

        // Push one frame, then assert reset in the middle of a second CALL.
        drive(0, CALL, 3, 8'h00, 0, 0, 0, 8'h00);
        @(posedge clk); #1;
        check("call_pre_rst", 8'h50, 1'b0, 2'b00, 3'd1);
        drive(0, CALL, 3, 8'h00, 0, 1, 4, 8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 8'h00, 1'b0, 2'b00, 3'd0);
        @(posedge clk); #1;
        check("rst_hold", 8'h00, 1'b0, 2'b00, 3'd0);
        rst_n = 1'b1;

        // Label validity must be gone after reset.
        drive(0, JMP, 3, 8'h00, 0, 0, 0, 8'h00);
        @(posedge clk); #1;
        check("lbl_cleared", 8'h04, 1'b1, 2'b01, 3'd0);
        drive(0, RET, 0, 8'h00, 0, 0, 0, 8'h00);
        @(posedge clk); #1;
        check("stk_cleared", 8'h08, 1'b1, 2'b10, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_label_unit.md
Name: pc_label_unit

Overview:
- Registered program-counter unit with a software-programmable label (jump-target) table and a small hardware return stack.
- Generalises a fixed label-to-PC decode: label addresses are written at run time, and PC width, table depth, stack depth and step size are parameters.
- Each cycle it resolves the next PC from sequential, label-jump, conditional-branch, absolute-jump, call and return operations.
- Sits between instruction decode and instruction-memory address generation.

Parameters:
- PC_W, 8, program counter and label width in bits.
- NUM_LABELS, 8, label table entries; power of two, ≥2.
- IDX_W, $clog2(NUM_LABELS), label index width.
- STACK_DEPTH, 4, return-stack entries, ≥1.
- PC_STEP, 4, sequential increment.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  1 = hold PC and stack; the op is ignored.
- op  in  3  000 SEQ, 001 JMP_LBL, 010 BR_LBL, 011 JMP_ABS, 100 CALL, 101 RET, 11x reserved.
- label_idx  in  IDX_W  label used by JMP_LBL, BR_LBL and CALL.
- abs_target  in  PC_W  target for JMP_ABS.
- cond  in  1  branch condition for BR_LBL.
- lbl_we  in  1  label table write enable.
- lbl_waddr  in  IDX_W  label table write index.
- lbl_wdata  in  PC_W  label table write value.
- pc  out  PC_W  current PC (registered).
- err  out  1  one-cycle registered error pulse.
- err_code  out  2  00 none, 01 invalid label, 10 stack overflow/underflow, 11 reserved op.
- stack_cnt  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC, err = 0, err_code = 00, stack_cnt = 0.
  - All label valid bits cleared; label data is don't-care.
- Definitions:
  - seq = (pc + PC_STEP) mod 2^PC_W; wrap-around is silent and not an error.
  - Latency: the op sampled in cycle N produces the new pc visible after edge N+1.
- Label table:
  - lbl_we writes lbl_wdata and sets valid[lbl_waddr].
  - Writes occur even when stall = 1.
  - A same-cycle write and lookup on the same index uses the old contents; the new value is visible from the next cycle.
- Ops (when stall = 0):
  - SEQ: pc ← seq.
  - JMP_LBL: if valid[label_idx], pc ← table[label_idx]; else pc ← seq, err_code 01.
  - BR_LBL: if cond = 0, pc ← seq with no label check. If cond = 1, behaves as JMP_LBL.
  - JMP_ABS: pc ← abs_target.
  - CALL: requires a valid label and stack_cnt < STACK_DEPTH.
    - Then push seq, pc ← label value, stack_cnt+1.
    - Invalid label: code 01, no push, pc ← seq. The invalid-label error has priority over overflow.
    - Stack full: code 10, no push, pc ← seq.
  - RET: if stack_cnt > 0, pc ← top, pop, stack_cnt−1. If empty: code 10, pc ← seq.
  - 11x: pc ← seq, code 11.
- Error signalling:
  - err = 1 for exactly the cycle after any error; err_code holds the code that cycle.
  - Both return to 0/00 the next cycle unless another error occurs.
- stall = 1: pc, stack and stack_cnt are held, err is cleared, and no error is ever raised.
- Stack is LIFO. Entries persist after a pop but are never read at or beyond stack_cnt.
- Reset asserted mid-operation overrides everything immediately, including a pending push or write.

Test Plan:
- Release reset, 3 cycles SEQ → pc = 0x00, 0x04, 0x08, 0x0C; err = 0, stack_cnt = 0.
- Write label2 = 0x38; next cycle JMP_LBL idx 2 → pc = 0x38. JMP_LBL idx 5 (never written) → pc = 0x3C, err = 1, err_code = 01 for one cycle.
- pc = 0x10, label3 = 0x50, CALL idx 3 → pc = 0x50, stack_cnt = 1. Then SEQ → 0x54. RET → pc = 0x14, stack_cnt = 0. RET again → pc = 0x18, err_code = 10.
- Four CALLs to a valid label → stack_cnt = 4. Fifth CALL → err_code = 10, stack_cnt stays 4, pc = seq. Four RETs → return addresses pop in reverse push order.
- Same cycle: lbl_we to idx 1 with 0x80 and JMP_LBL idx 1 (old value 0x20) → pc = 0x20. Repeat the jump → pc = 0x80.
- pc = 0xFC, SEQ → pc = 0x00 with no err. stall = 1 with op = JMP_ABS 0x44 → pc unchanged. Assert rst_n = 0 mid-CALL → pc = 0x00 and stack_cnt = 0 immediately.
